// File: rtl/seven_segment_write_arbiter.sv
// rtl/seven_segment_write_arbiter.sv - two-port round-robin write arbiter feeding a scanned seven-segment frame buffer
module seven_segment_write_arbiter #(
  parameter int clk_mhz     = 25,
  parameter int w_digit     = 8,
  parameter int scan_period = clk_mhz * 1000,
  parameter int w_index     = $clog2(w_digit)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [w_index-1:0] req0_index,
  input  logic [7:0]         req0_seg,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [w_index-1:0] req1_index,
  input  logic [7:0]         req1_seg,
  output logic [7:0]         abcdefgh,
  output logic [w_digit-1:0] digit,
  output logic               last_owner
);

  localparam int pw = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam int cw = (scan_period > 1) ? $clog2(scan_period) : 1;
  localparam logic [pw-1:0] last_ptr = pw'(w_digit - 1);
  localparam logic [cw-1:0] last_cnt = cw'(scan_period - 1);

  logic [7:0]    buffer [w_digit];
  logic [cw-1:0] scan_cnt;
  logic [pw-1:0] ptr;
  logic          grant0, grant1;
  logic          hit0, hit1;

  // On contention the port that did not win last time goes first.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_owner);
    grant1 = req1_valid && (!req0_valid || !last_owner);
    hit0   = 32'(req0_index) < w_digit;
    hit1   = 32'(req1_index) < w_digit;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < w_digit; i++) buffer[i] <= 8'h00;
      scan_cnt   <= '0;
      ptr        <= '0;
      last_owner <= 1'b1;
      abcdefgh   <= 8'h00;
      digit      <= '0;
    end else begin
      // Out-of-range indices complete the handshake but leave the buffer alone.
      if (grant0) begin
        if (hit0) buffer[req0_index[pw-1:0]] <= req0_seg;
        last_owner <= 1'b0;
      end else if (grant1) begin
        if (hit1) buffer[req1_index[pw-1:0]] <= req1_seg;
        last_owner <= 1'b1;
      end

      if (scan_cnt == last_cnt) begin
        scan_cnt <= '0;
        ptr      <= (ptr == last_ptr) ? '0 : ptr + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // Select and pattern come from the same pointer sample, so they never disagree.
      digit    <= w_digit'(1) << ptr;
      abcdefgh <= buffer[ptr];
    end
  end

endmodule

// File: tb/tb_seven_segment_write_arbiter.sv
// tb/tb_seven_segment_write_arbiter.sv - directed self-checking bench for seven_segment_write_arbiter
module tb_seven_segment_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_index, req1_index;
  logic [7:0] req0_seg, req1_seg;
  logic [7:0] abcdefgh;
  logic [7:0] digit;
  logic       last_owner;

  logic       f_ready0, f_ready1, f_owner;
  logic [7:0] f_seg, f_digit;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int idx;
  logic       exp0;
  logic [7:0] exp_buf [8];

  always #5 clk = ~clk;

  seven_segment_write_arbiter #(
    .w_digit(8), .scan_period(4), .w_index(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_index(req0_index), .req0_seg(req0_seg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_index(req1_index), .req1_seg(req1_seg),
    .abcdefgh(abcdefgh), .digit(digit), .last_owner(last_owner)
  );

  seven_segment_write_arbiter #(
    .w_digit(8), .scan_period(1), .w_index(4)
  ) fast (
    .clk(clk), .rst(rst),
    .req0_valid(1'b0), .req0_ready(f_ready0), .req0_index(4'd0), .req0_seg(8'h00),
    .req1_valid(1'b0), .req1_ready(f_ready1), .req1_index(4'd0), .req1_seg(8'h00),
    .abcdefgh(f_seg), .digit(f_digit), .last_owner(f_owner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) n = 0;
    else n++;
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_dig(input int k);
    return 8'(1) << (((k - 1) / 4) % 8);
  endfunction

  initial begin
    req0_valid = 0; req1_valid = 0;
    req0_index = 0; req1_index = 0;
    req0_seg = 0; req1_seg = 0;
    @(negedge clk);

    // Arbitration runs during reset but writes must not land.
    req0_valid = 1; req0_index = 0; req0_seg = 8'hFF;
    #1;
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 0);
    tick();
    chk("rst_digit", digit, 0);
    chk("rst_seg", abcdefgh, 0);
    chk("rst_owner", last_owner, 1);
    req0_valid = 0; req1_valid = 1; req1_index = 1; req1_seg = 8'h77;
    #1;
    chk("rst_ready1_alone", req1_ready, 1);
    chk("rst_ready0_idle", req0_ready, 0);
    tick();
    req1_valid = 0;

    // Idle scan: each digit held 4 cycles, blank patterns.
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("idle_digit", digit, exp_dig(n));
      chk("idle_seg", abcdefgh, 0);
      chk("fast_digit", f_digit, 8'(1) << ((n - 1) % 8));
    end

    // Contention on the same index right after reset.
    rst = 1;
    tick();
    rst = 0;
    req0_valid = 1; req0_index = 2; req0_seg = 8'hFC;
    req1_valid = 1; req1_index = 2; req1_seg = 8'h60;
    #1;
    chk("same_ready0_first", req0_ready, 1);
    chk("same_ready1_first", req1_ready, 0);
    tick();
    chk("same_owner_after0", last_owner, 0);
    chk("same_ready0_second", req0_ready, 0);
    chk("same_ready1_second", req1_ready, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("same_owner_after1", last_owner, 1);
    while (n < 9) tick();
    chk("same_digit", digit, 8'h04);
    chk("same_seg", abcdefgh, 8'h60);

    // Sustained contention alternates grants.
    req0_valid = 1; req0_index = 3; req0_seg = 8'h11;
    req1_valid = 1; req1_index = 4; req1_seg = 8'h22;
    #1;
    exp0 = 1;
    for (int i = 0; i < 10; i++) begin
      chk("rr_ready0", req0_ready, exp0);
      chk("rr_ready1", req1_ready, !exp0);
      tick();
      exp0 = !exp0;
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_owner", last_owner, 1);

    // Single-port zero-wait grant, then an out-of-range write.
    req0_valid = 1; req0_index = 5; req0_seg = 8'h5B;
    #1;
    chk("solo0_ready0", req0_ready, 1);
    chk("solo0_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("solo0_owner", last_owner, 0);
    req1_valid = 1; req1_index = 9; req1_seg = 8'hAA;
    #1;
    chk("oob_ready1", req1_ready, 1);
    chk("oob_ready0", req0_ready, 0);
    tick();
    req1_valid = 0;
    chk("oob_owner", last_owner, 1);

    exp_buf = '{8'h00, 8'h00, 8'h60, 8'h11, 8'h22, 8'h5B, 8'h00, 8'h00};
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("scan_digit", digit, exp_dig(n));
      chk("scan_seg", abcdefgh, exp_buf[((n - 1) / 4) % 8]);
    end

    // Write to the digit that will be read at the following edge.
    idx = ((n + 1) / 4) % 8;
    req0_valid = 1; req0_index = 4'(idx); req0_seg = 8'hB6;
    #1;
    chk("lat_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    tick();
    chk("lat_seg", abcdefgh, 8'hB6);
    chk("lat_digit", digit, 8'(1) << idx);

    // Mid-scan reset wipes everything.
    rst = 1;
    tick();
    chk("mid_rst_digit", digit, 0);
    chk("mid_rst_seg", abcdefgh, 0);
    chk("mid_rst_owner", last_owner, 1);
    rst = 0;
    tick();
    chk("post_rst_digit", digit, 8'h01);
    chk("post_rst_seg", abcdefgh, 8'h00);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("clear_digit", digit, exp_dig(n));
      chk("clear_seg", abcdefgh, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
